// File: rtl/set_region_counter.sv
// set_region_counter: counts lattice points (x,y), 1..GRID on each axis, that satisfy
// a selectable set expression over membership in up to NCIRC circles.
//   clk       rising-edge clock
//   rst       asynchronous active-high reset; aborts any job in flight
//   en        job start strobe, sampled only while busy=0
//   central   circle centres {x0,y0,x1,y1,...}, circle 0 in the MSBs
//   radius    radii {r0,r1,...}, r0 in the MSBs
//   mode      set expression select, captured with en
//   busy      job in progress (SCAN and DONE)
//   valid     one-cycle result strobe (DONE)
//   candidate point count, held until the next job's DONE
// Optional feature: define SET_PARALLEL_EN to scan a whole row per cycle.
module set_region_counter #(
    parameter int CW    = 4,
    parameter int GRID  = 8,
    parameter int NCIRC = 3,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [2*CW*NCIRC-1:0]   central,
    input  logic [CW*NCIRC-1:0]     radius,
    input  logic [2:0]              mode,
    output logic                    busy,
    output logic                    valid,
    output logic [CNT_W-1:0]        candidate
);
    localparam int SW = 2*CW+3;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                  state, state_nxt;
    logic [2*CW*NCIRC-1:0]   cen_q;
    logic [CW*NCIRC-1:0]     rad_q;
    logic [2:0]              mode_q;
    logic [CW-1:0]           y;
    logic [CNT_W-1:0]        acc, acc_nxt;
    logic                    last;

    // Distances use the magnitude of the coordinate difference, which squares to
    // the same value as the signed difference and never overflows SW bits.
    function automatic logic in_set(input logic [CW-1:0] px, input logic [CW-1:0] py);
        logic [3:0]    m;
        logic [2:0]    n;
        logic [CW-1:0] cx, cy, r;
        logic [SW-1:0] ax, ay;
        m = '0;
        n = '0;
        for (int i = 0; i < NCIRC; i++) begin
            cx   = cen_q[2*CW*(NCIRC-i)-1 -: CW];
            cy   = cen_q[2*CW*(NCIRC-i)-CW-1 -: CW];
            r    = rad_q[CW*(NCIRC-i)-1 -: CW];
            ax   = SW'(px >= cx ? px - cx : cx - px);
            ay   = SW'(py >= cy ? py - cy : cy - py);
            m[i] = ax*ax + ay*ay <= SW'(r)*SW'(r);
            n    = n + {2'b0, m[i]};
        end
        return mode_q == 3'd0 ? m[0] :
               mode_q == 3'd1 ? m[0] | m[1] :
               mode_q == 3'd2 ? m[0] ^ m[1] :
               mode_q == 3'd3 ? m[0] & m[1] :
               mode_q == 3'd4 ? n == 3'(NCIRC) :
               mode_q == 3'd5 ? n == 3'd1 :
               mode_q == 3'd6 ? n >= 3'd2 :
                                n == 3'd2;
    endfunction

`ifdef SET_PARALLEL_EN
    // One row per cycle: GRID membership units feeding a popcount adder.
    assign last = y == CW'(GRID);

    always_comb begin
        acc_nxt = acc;
        for (int i = 1; i <= GRID; i++)
            acc_nxt = acc_nxt + CNT_W'(in_set(CW'(i), y));
    end
`else
    logic [CW-1:0] x;

    assign last    = x == CW'(GRID) && y == CW'(GRID);
    assign acc_nxt = acc + CNT_W'(in_set(x, y));
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;

    always_comb begin
        state_nxt = state == IDLE ? (en ? SCAN : IDLE) :
                    state == SCAN ? (last ? DONE : SCAN) : IDLE;
        busy      = state != IDLE;
        valid     = state == DONE;
    end

    // candidate is loaded on the last scan edge so it is already valid during DONE.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cen_q     <= '0;
            rad_q     <= '0;
            mode_q    <= '0;
            acc       <= '0;
            candidate <= '0;
            y         <= '0;
`ifndef SET_PARALLEL_EN
            x         <= '0;
`endif
        end else if (state == IDLE && en) begin
            cen_q  <= central;
            rad_q  <= radius;
            mode_q <= mode;
            acc    <= '0;
            y      <= CW'(1);
`ifndef SET_PARALLEL_EN
            x      <= CW'(1);
`endif
        end else if (state == SCAN) begin
            acc <= acc_nxt;
            if (last)
                candidate <= acc_nxt;
`ifdef SET_PARALLEL_EN
            y <= y + CW'(1);
`else
            x <= x == CW'(GRID) ? CW'(1) : x + CW'(1);
            y <= x == CW'(GRID) ? y + CW'(1) : y;
`endif
        end
endmodule

// File: tb/tb_set_region_counter.sv
// tb_set_region_counter: directed self-checking bench for set_region_counter.
module tb_set_region_counter;
`ifdef SET_PARALLEL_EN
    localparam int LAT = 9;
`else
    localparam int LAT = 65;
`endif
    localparam int POKE = LAT > 10 ? 10 : 4;
    localparam int RST_AT = LAT > 30 ? 30 : 6;

    logic        clk = 0;
    logic        rst = 1;
    logic        en = 0;
    logic [23:0] central = '0;
    logic [11:0] radius = '0;
    logic [2:0]  mode = '0;
    logic        busy, valid;
    logic [7:0]  candidate;
    int          total = 0;
    int          bad = 0;

    set_region_counter dut (
        .clk(clk), .rst(rst), .en(en), .central(central), .radius(radius),
        .mode(mode), .busy(busy), .valid(valid), .candidate(candidate)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    // Runs one job; poke>0 pulses en with other inputs at that cycle,
    // rst_at>0 asserts reset at that cycle and ends the job there.
    task automatic job(input string tag, input logic [23:0] c, input logic [11:0] r,
                       input logic [2:0] md, input int want, input int poke, input int rst_at);
        int k;
        @(negedge clk);
        central = c; radius = r; mode = md; en = 1;
        @(negedge clk);
        en = 0;
        central = ~c; radius = ~r; mode = ~md;
        k = 1;
        chk({tag, ".busy_start"}, int'(busy), 1);
        while (!valid && k < LAT + 20) begin
            if (rst_at > 0 && k == rst_at) begin
                rst = 1;
                #1;
                chk({tag, ".rst_busy"}, int'(busy), 0);
                chk({tag, ".rst_valid"}, int'(valid), 0);
                chk({tag, ".rst_cand"}, int'(candidate), 0);
                @(negedge clk);
                rst = 0;
                return;
            end
            if (k == poke) begin
                central = {4'd1, 4'd1, 8'd0, 8'd0}; radius = 12'hF00; mode = 3'd0; en = 1;
            end else
                en = 0;
            @(negedge clk);
            k++;
        end
        en = 0;
        chk({tag, ".latency"}, k, LAT);
        chk({tag, ".cand"}, int'(candidate), want);
        chk({tag, ".busy_done"}, int'(busy), 1);
        @(negedge clk);
        chk({tag, ".valid_pulse"}, int'(valid), 0);
        chk({tag, ".busy_idle"}, int'(busy), 0);
        chk({tag, ".cand_hold"}, int'(candidate), want);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset.busy", int'(busy), 0);
        chk("reset.valid", int'(valid), 0);
        chk("reset.cand", int'(candidate), 0);
        rst = 0;
        job("pt_r0",   {4'd4, 4'd4, 16'd0}, 12'h000, 3'b000, 1, 0, 0);
        job("full",    {4'd1, 4'd1, 16'd0}, 12'hF00, 3'b000, 64, 0, 0);
        job("ab_or",   {4'd4, 4'd4, 4'd5, 4'd4, 8'd0}, 12'h110, 3'b001, 8, 0, 0);
        job("ab_xor",  {4'd4, 4'd4, 4'd5, 4'd4, 8'd0}, 12'h110, 3'b010, 6, 0, 0);
        job("ab_and",  {4'd4, 4'd4, 4'd5, 4'd4, 8'd0}, 12'h110, 3'b011, 2, 0, 0);
        job("ab_a",    {4'd4, 4'd4, 4'd5, 4'd4, 8'd0}, 12'h110, 3'b000, 5, 0, 0);
        job("abc_all", {4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4}, 12'h111, 3'b100, 5, 0, 0);
        job("abc_one", {4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4}, 12'h111, 3'b101, 0, 0, 0);
        job("abc_ge2", {4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4}, 12'h111, 3'b110, 5, 0, 0);
        job("abc_two", {4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4}, 12'h111, 3'b111, 0, 0, 0);
        job("c88_one", {4'd4, 4'd4, 4'd4, 4'd4, 4'd8, 4'd8}, 12'h110, 3'b101, 1, 0, 0);
        job("c88_two", {4'd4, 4'd4, 4'd4, 4'd4, 4'd8, 4'd8}, 12'h110, 3'b111, 5, 0, 0);
        job("en_busy", {4'd4, 4'd4, 16'd0}, 12'h000, 3'b000, 1, POKE, 0);
        job("abort",   {4'd1, 4'd1, 16'd0}, 12'hF00, 3'b000, 64, 0, RST_AT);
        chk("abort.idle_valid", int'(valid), 0);
        job("post_rst", {4'd4, 4'd4, 4'd5, 4'd4, 8'd0}, 12'h110, 3'b001, 8, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
